// File: rtl/bcd4_down_counter_if.sv
// Bundle of the control, load and count signals for bcd4_down_counter.
// master drives ce/ld/d0..d3 and observes q0..q3/tc/ceo.
// slave is the counter side.
//   ce     count enable          ld     parallel load strobe
//   d0..d3 load digits (BCD)     q0..q3 count digits (registered)
//   tc     count is 0000         ceo    borrow out = ce & tc
interface bcd4_down_counter_if;
  logic       ce;
  logic       ld;
  logic [3:0] d0;
  logic [3:0] d1;
  logic [3:0] d2;
  logic [3:0] d3;
  logic [3:0] q0;
  logic [3:0] q1;
  logic [3:0] q2;
  logic [3:0] q3;
  logic       tc;
  logic       ceo;

  modport master (
    output ce, ld, d0, d1, d2, d3,
    input  q0, q1, q2, q3, tc, ceo
  );

  modport slave (
    input  ce, ld, d0, d1, d2, d3,
    output q0, q1, q2, q3, tc, ceo
  );
endinterface

// File: rtl/bcd4_down_counter.sv
// 4-digit BCD down-counter (0000..9999) with parallel load and borrow chain.
// Counts one step per clock while ce is high; tc flags 0000 and ceo = ce & tc
// so ceo can drive ce of a more significant instance.
// Ports:
//   clk     clock, rising edge
//   r       synchronous active-high reset
//   if_cnt  slave side of bcd4_down_counter_if (ce, ld, d0..d3 in; q0..q3, tc, ceo out)
// Parameter:
//   AUTO_RELOAD  0: 0000 decrements to 9999; 1: 0000 reloads the last loaded value
module bcd4_down_counter #(
  parameter int unsigned AUTO_RELOAD = 0
) (
  input logic                 clk,
  input logic                 r,
  bcd4_down_counter_if.slave  if_cnt
);

  logic [3:0] r_q      [4];
  logic [3:0] r_reload [4];
  logic [3:0] w_d      [4];
  logic [3:0] w_dec    [4];
  logic [4:0] w_borrow;
  logic       w_zero;

  function automatic logic [3:0] clamp_digit(input logic [3:0] dig);
    return (dig > 4'd9) ? 4'd9 : dig;
  endfunction

  always_comb begin
    w_d[0] = clamp_digit(if_cnt.d0);
    w_d[1] = clamp_digit(if_cnt.d1);
    w_d[2] = clamp_digit(if_cnt.d2);
    w_d[3] = clamp_digit(if_cnt.d3);
  end

  // Ripple borrow: digit i steps only when every lower digit is 0.
  always_comb begin
    w_borrow[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w_borrow[i+1] = w_borrow[i] & (r_q[i] == 4'd0);
      if (w_borrow[i]) begin
        w_dec[i] = (r_q[i] == 4'd0) ? 4'd9 : r_q[i] - 4'd1;
      end else begin
        w_dec[i] = r_q[i];
      end
    end
    // All four borrows propagated means the count is 0000.
    w_zero = w_borrow[4];
  end

  always_ff @(posedge clk) begin
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i]      <= 4'd0;
        r_reload[i] <= 4'd0;
      end
    end else if (if_cnt.ld) begin
      for (int i = 0; i < 4; i++) begin
        r_q[i]      <= w_d[i];
        r_reload[i] <= w_d[i];
      end
    end else if (if_cnt.ce) begin
      // Without auto-reload the plain borrow chain already wraps 0000 -> 9999.
      if (w_zero && (AUTO_RELOAD != 0)) begin
        for (int i = 0; i < 4; i++) r_q[i] <= r_reload[i];
      end else begin
        for (int i = 0; i < 4; i++) r_q[i] <= w_dec[i];
      end
    end
  end

  assign if_cnt.q0  = r_q[0];
  assign if_cnt.q1  = r_q[1];
  assign if_cnt.q2  = r_q[2];
  assign if_cnt.q3  = r_q[3];
  assign if_cnt.tc  = w_zero;
  assign if_cnt.ceo = if_cnt.ce & w_zero;

endmodule
